// File: rtl/cpu6_csrfile.sv
// cpu6_csrfile -- machine-mode CSR file for the cpu6 core.
//
// Holds mstatus (MIE/MPIE), misa (read-only), mtvec, mscratch, mepc, mcause
// and the 64-bit mcycle/minstret counters. Reads are combinational. Writes,
// trap entry and MRET update state on the rising edge.
//
// Ports:
//   clk, reset            core clock; asynchronous active-high reset
//   csr_valid/op/imm_sel  CSR instruction qualifier, operation, operand select
//   csr_idx               CSR address
//   csr_rs1_dat/zimm      register or immediate source operand
//   csr_src_zero          source is x0 / zimm==0 (RS/RC must not write)
//   exc_valid/cause/pc    trap request
//   mret_valid            MRET retiring
//   instret_inc           one instruction retired this cycle
//   csr_read_dat          current value of CSR csr_idx (combinational)
//   csr_write_dat         value that would be written (combinational)
//   illegal_csr           unimplemented index or write to a read-only CSR
//   trap_redirect/pc      registered one-cycle fetch redirect and its target
module cpu6_csrfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_valid,
  input  logic [1:0]  csr_op,
  input  logic        csr_imm_sel,
  input  logic [11:0] csr_idx,
  input  logic [31:0] csr_rs1_dat,
  input  logic [4:0]  csr_zimm,
  input  logic        csr_src_zero,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        mret_valid,
  input  logic        instret_inc,
  output logic [31:0] csr_read_dat,
  output logic [31:0] csr_write_dat,
  output logic        illegal_csr,
  output logic        trap_redirect,
  output logic [31:0] trap_pc
);

  localparam logic [1:0]  OP_RW = 2'b01;
  localparam logic [1:0]  OP_RS = 2'b10;
  localparam logic [1:0]  OP_RC = 2'b11;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  logic        mie_reg, mpie_reg;
  logic [31:2] mtvec_reg;
  logic [31:0] mscratch_reg;
  logic [31:2] mepc_reg;
  logic        mcause_int_reg;
  logic [3:0]  mcause_code_reg;
  logic [63:0] mcycle_reg, minstret_reg;
  logic        trap_redirect_reg;
  logic [31:0] trap_pc_reg;

  logic        idx_hit;
  logic        idx_ro;
  logic [31:0] src;
  logic        write_attempt;
  logic        we;

  // Read mux; idx_hit marks implemented addresses.
  always_comb begin
    idx_hit      = 1'b1;
    csr_read_dat = 32'h0;
    case (csr_idx)
      A_MSTATUS:   csr_read_dat = {24'h0, mpie_reg, 3'b000, mie_reg, 3'b000};
      A_MISA:      csr_read_dat = MISA_VAL;
      A_MTVEC:     csr_read_dat = {mtvec_reg, 2'b00};
      A_MSCRATCH:  csr_read_dat = mscratch_reg;
      A_MEPC:      csr_read_dat = {mepc_reg, 2'b00};
      A_MCAUSE:    csr_read_dat = {mcause_int_reg, 27'h0, mcause_code_reg};
      A_MCYCLE:    csr_read_dat = mcycle_reg[31:0];
      A_MCYCLEH:   csr_read_dat = mcycle_reg[63:32];
      A_MINSTRET:  csr_read_dat = minstret_reg[31:0];
      A_MINSTRETH: csr_read_dat = minstret_reg[63:32];
      default:     idx_hit = 1'b0;
    endcase
  end

  assign idx_ro = (csr_idx == A_MISA);
  assign src    = csr_imm_sel ? {27'h0, csr_zimm} : csr_rs1_dat;

  always_comb begin
    case (csr_op)
      OP_RW:   csr_write_dat = src;
      OP_RS:   csr_write_dat = csr_read_dat | src;
      OP_RC:   csr_write_dat = csr_read_dat & ~src;
      default: csr_write_dat = csr_read_dat;
    endcase
  end

  // RS/RC with a zero source are pure reads: they never write and so never
  // trip the read-only check.
  assign write_attempt = (csr_op == OP_RW) |
                         (((csr_op == OP_RS) | (csr_op == OP_RC)) & ~csr_src_zero);
  assign illegal_csr   = csr_valid & (~idx_hit | (idx_ro & write_attempt));
  // A coinciding trap or MRET takes priority and drops the CSR write.
  assign we            = csr_valid & write_attempt & ~illegal_csr & ~exc_valid & ~mret_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mie_reg           <= 1'b0;
      mpie_reg          <= 1'b0;
      mtvec_reg         <= '0;
      mscratch_reg      <= '0;
      mepc_reg          <= '0;
      mcause_int_reg    <= 1'b0;
      mcause_code_reg   <= '0;
      mcycle_reg        <= '0;
      minstret_reg      <= '0;
      trap_redirect_reg <= 1'b0;
      trap_pc_reg       <= '0;
    end else begin
      trap_redirect_reg <= 1'b0;

      // Writing either counter half freezes the whole counter for that cycle.
      if (we && csr_idx == A_MCYCLE)
        mcycle_reg <= {mcycle_reg[63:32], csr_write_dat};
      else if (we && csr_idx == A_MCYCLEH)
        mcycle_reg <= {csr_write_dat, mcycle_reg[31:0]};
      else
        mcycle_reg <= mcycle_reg + 64'd1;

      if (we && csr_idx == A_MINSTRET)
        minstret_reg <= {minstret_reg[63:32], csr_write_dat};
      else if (we && csr_idx == A_MINSTRETH)
        minstret_reg <= {csr_write_dat, minstret_reg[31:0]};
      else if (instret_inc)
        minstret_reg <= minstret_reg + 64'd1;

      if (exc_valid) begin
        mepc_reg          <= exc_pc[31:2];
        mcause_int_reg    <= 1'b0;
        mcause_code_reg   <= exc_cause;
        mpie_reg          <= mie_reg;
        mie_reg           <= 1'b0;
        trap_redirect_reg <= 1'b1;
        trap_pc_reg       <= {mtvec_reg, 2'b00};
      end else if (mret_valid) begin
        mie_reg           <= mpie_reg;
        mpie_reg          <= 1'b1;
        trap_redirect_reg <= 1'b1;
        trap_pc_reg       <= {mepc_reg, 2'b00};
      end else if (we) begin
        case (csr_idx)
          A_MSTATUS: begin
            mie_reg  <= csr_write_dat[3];
            mpie_reg <= csr_write_dat[7];
          end
          A_MTVEC:    mtvec_reg    <= csr_write_dat[31:2];
          A_MSCRATCH: mscratch_reg <= csr_write_dat;
          A_MEPC:     mepc_reg     <= csr_write_dat[31:2];
          A_MCAUSE: begin
            mcause_int_reg  <= csr_write_dat[31];
            mcause_code_reg <= csr_write_dat[3:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign trap_redirect = trap_redirect_reg;
  assign trap_pc       = trap_pc_reg;

  // The low pc bits are architecturally discarded on trap entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^exc_pc[1:0];

endmodule

// File: tb/tb_cpu6_csrfile.sv
// Scoreboard bench for cpu6_csrfile: the stimulus process drives one vector
// per cycle and queues its hand-computed expectations; a monitor on the
// falling edge pops and compares them.
module tb_cpu6_csrfile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_valid = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic        csr_imm_sel = 1'b0;
  logic [11:0] csr_idx = 12'h0;
  logic [31:0] csr_rs1_dat = 32'h0;
  logic [4:0]  csr_zimm = 5'h0;
  logic        csr_src_zero = 1'b0;
  logic        exc_valid = 1'b0;
  logic [3:0]  exc_cause = 4'h0;
  logic [31:0] exc_pc = 32'h0;
  logic        mret_valid = 1'b0;
  logic        instret_inc = 1'b0;
  logic [31:0] csr_read_dat, csr_write_dat, trap_pc;
  logic        illegal_csr, trap_redirect;

  localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;

  cpu6_csrfile dut (
    .clk(clk), .reset(reset), .csr_valid(csr_valid), .csr_op(csr_op),
    .csr_imm_sel(csr_imm_sel), .csr_idx(csr_idx), .csr_rs1_dat(csr_rs1_dat),
    .csr_zimm(csr_zimm), .csr_src_zero(csr_src_zero), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_pc(exc_pc), .mret_valid(mret_valid),
    .instret_inc(instret_inc), .csr_read_dat(csr_read_dat),
    .csr_write_dat(csr_write_dat), .illegal_csr(illegal_csr),
    .trap_redirect(trap_redirect), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit          chk_rd;
    logic [31:0] rd;
    bit          ill;
    bit          redir;
    bit          chk_tpc;
    logic [31:0] tpc;
    bit          chk_wd;
    logic [31:0] wd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
    end
  endtask

  // Monitor: one expectation per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_rd)  cmp(e.nm, "read_dat", csr_read_dat, e.rd);
      cmp(e.nm, "illegal", {31'h0, illegal_csr}, {31'h0, e.ill});
      cmp(e.nm, "redirect", {31'h0, trap_redirect}, {31'h0, e.redir});
      if (e.chk_tpc) cmp(e.nm, "trap_pc", trap_pc, e.tpc);
      if (e.chk_wd)  cmp(e.nm, "write_dat", csr_write_dat, e.wd);
      $display("cycle %-14s idx=%h rd=%h ill=%0b redir=%0b tpc=%h",
               e.nm, csr_idx, csr_read_dat, illegal_csr, trap_redirect, trap_pc);
    end
  end

  task automatic idle();
    csr_valid = 1'b0; csr_op = 2'b00; csr_imm_sel = 1'b0; csr_zimm = 5'h0;
    csr_rs1_dat = 32'h0; csr_src_zero = 1'b0; exc_valid = 1'b0;
    exc_cause = 4'h0; exc_pc = 32'h0; mret_valid = 1'b0; instret_inc = 1'b0;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] idx, input logic [31:0] dat, input bit zero = 1'b0);
    csr_valid = 1'b1; csr_op = op; csr_idx = idx; csr_rs1_dat = dat; csr_src_zero = zero;
  endtask

  task automatic peek(input logic [11:0] idx);
    csr_valid = 1'b0; csr_idx = idx;
  endtask

  // Queue the expectation for the vector currently on the inputs, then
  // advance one cycle and return the inputs to idle.
  task automatic go(input string nm, input bit chk_rd, input logic [31:0] rd, input bit ill,
                    input bit redir = 1'b0, input logic [31:0] tpc = 32'h0,
                    input bit chk_wd = 1'b0, input logic [31:0] wd = 32'h0);
    exp_t e;
    e.nm = nm; e.chk_rd = chk_rd; e.rd = rd; e.ill = ill; e.redir = redir;
    e.chk_tpc = redir | reset; e.tpc = tpc; e.chk_wd = chk_wd; e.wd = wd;
    sb.push_back(e);
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    // Held in reset
    peek(12'h300); go("rst_mstatus", 1, 32'h0, 0);
    peek(12'h301); go("rst_misa", 1, 32'h4000_0100, 0);
    peek(12'hB00); go("rst_mcycle", 1, 32'h0, 0);
    reset = 1'b0;

    // CSRRSI mepc, zimm 4
    csr(RS, 12'h341, 32'h0); csr_imm_sel = 1'b1; csr_zimm = 5'd4;
    go("rsi_mepc", 1, 32'h0, 0, 0, 0, 1, 32'h4);
    peek(12'h341); go("mepc_4", 1, 32'h4, 0);
    // CSRRS with rs1 = x0: read only, even though rs1 data is nonzero
    csr(RS, 12'h341, 32'h8, 1'b1); go("rs_x0_mepc", 1, 32'h4, 0, 0, 0, 1, 32'hC);
    peek(12'h341); go("mepc_kept", 1, 32'h4, 0);
    csr(RC, 12'h341, 32'h4); go("rc_mepc", 1, 32'h4, 0, 0, 0, 1, 32'h0);
    peek(12'h341); go("mepc_clr", 1, 32'h0, 0);

    // mtvec / mstatus setup
    csr(RW, 12'h305, 32'h101); go("rw_mtvec", 1, 32'h0, 0, 0, 0, 1, 32'h101);
    csr(RW, 12'h300, 32'hFFFF_FFFF); go("rw_mstatus", 1, 32'h0, 0);
    peek(12'h305); go("mtvec_rd", 1, 32'h100, 0);
    peek(12'h300); go("mstatus_rd", 1, 32'h88, 0);

    // Trap with simultaneous CSR write (dropped)
    csr(RW, 12'h340, 32'h55); exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h1E;
    go("trap", 1, 32'h0, 0);
    peek(12'h341); go("trap_mepc", 1, 32'h1C, 0, 1, 32'h100);
    peek(12'h342); go("trap_mcause", 1, 32'h2, 0);
    peek(12'h300); go("trap_mstatus", 1, 32'h80, 0);
    peek(12'h340); go("trap_dropwr", 1, 32'h0, 0);

    // MRET
    peek(12'h341); mret_valid = 1'b1; go("mret", 1, 32'h1C, 0);
    peek(12'h300); go("mret_mstatus", 1, 32'h88, 0, 1, 32'h1C);

    // Illegal accesses
    csr(RW, 12'h301, 32'h0); go("rw_misa", 1, 32'h4000_0100, 1);
    csr(RW, 12'h7C0, 32'h5); go("rw_7c0", 1, 32'h0, 1);
    csr(RS, 12'h301, 32'h0, 1'b1); go("rs_x0_misa", 1, 32'h4000_0100, 0);
    peek(12'h301); go("misa_kept", 1, 32'h4000_0100, 0);

    // mcycle wrap
    csr(RW, 12'hB00, 32'hFFFF_FFFF); go("wr_mcycle", 0, 32'h0, 0);
    csr(RW, 12'hB80, 32'hFFFF_FFFF); go("wr_mcycleh", 0, 32'h0, 0);
    peek(12'hB80); go("mcycleh_ff", 1, 32'hFFFF_FFFF, 0);
    peek(12'hB00); go("mcycle_wrap", 1, 32'h0, 0);
    peek(12'hB80); go("mcycleh_wrap", 1, 32'h0, 0);
    peek(12'hB00); go("mcycle_2", 1, 32'h2, 0);

    // minstret: write suppresses increment, then carry into high half
    csr(RW, 12'hB02, 32'hFFFF_FFFE); instret_inc = 1'b1; go("wr_minstret", 0, 32'h0, 0);
    peek(12'hB02); instret_inc = 1'b1; go("minstret_fe", 1, 32'hFFFF_FFFE, 0);
    peek(12'hB82); instret_inc = 1'b1; go("minstreth_0", 1, 32'h0, 0);
    peek(12'hB82); go("minstreth_1", 1, 32'h1, 0);
    peek(12'hB02); go("minstret_0", 1, 32'h0, 0);

    // Reset mid-sequence
    csr(RW, 12'h340, 32'hAB); go("wr_mscratch", 1, 32'h0, 0);
    peek(12'h340); go("mscratch_ab", 1, 32'hAB, 0);
    reset = 1'b1; csr(RW, 12'h340, 32'h77); go("rst_mscratch", 1, 32'h0, 0);
    peek(12'h305); go("rst_mtvec", 1, 32'h0, 0);
    reset = 1'b0;
    peek(12'hB00); go("rel_mcycle0", 1, 32'h0, 0);
    peek(12'hB00); go("rel_mcycle1", 1, 32'h1, 0);
    peek(12'h300); go("rel_mstatus", 1, 32'h0, 0);
    peek(12'h341); go("rel_mepc", 1, 32'h0, 0);

    @(negedge clk); #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
